whack_hit_judge: RTL and testbench



---
 rtl/whack_hit_judge.sv | 162 ++++++++++++++++
 tb/tb_whack_hit_judge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/whack_hit_judge.sv
//------------------------------------------------------------------------------
// Module   : whack_hit_judge
// Purpose  : Turns raw mole buttons into judged hit/miss pulses, one score per lit mole.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module whack_hit_judge #(
  parameter int NUM_HOLES       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] btn_raw,
  input  logic [NUM_HOLES-1:0] mole_sel,
  output logic                 hit,
  output logic                 miss,
  output logic [NUM_HOLES-1:0] btn_clean,
  output logic                 lockout
);

  localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [NUM_HOLES-1:0] r_sync1;
  logic [NUM_HOLES-1:0] r_sync2;
  logic [NUM_HOLES-1:0] r_clean_d;
  logic [NUM_HOLES-1:0] r_mole_q;
  logic [NUM_HOLES-1:0] w_clean;
  logic [NUM_HOLES-1:0] w_press;
  logic                 w_mole_chg;
  logic                 w_any_press;
  logic                 w_correct;
  logic                 w_mole_lit;
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_hit_nxt;
  logic                 w_miss_nxt;
  logic                 r_hit;
  logic                 r_miss;
  logic                 r_lockout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any disagreement that does not persist for the full window restarts the count.
  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_clean;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_clean <= 1'b0;
      end else if (r_sync2[gi] != r_clean) begin
        if (r_cnt == c_db_last) begin
          r_cnt   <= '0;
          r_clean <= ~r_clean;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_clean[gi] = r_clean;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clean_d <= '0;
      r_mole_q  <= '0;
    end else begin
      r_clean_d <= w_clean;
      r_mole_q  <= mole_sel;
    end
  end

  assign w_press     = w_clean & ~r_clean_d;
  assign w_any_press = |w_press;
  assign w_correct   = |(w_press & mole_sel);
  assign w_mole_lit  = |mole_sel;
  assign w_mole_chg  = (mole_sel != r_mole_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_lockout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hit     <= w_hit_nxt;
      r_miss    <= w_miss_nxt;
      r_lockout <= (w_state_nxt == LOCKED);
    end
  end

  // A correct press always wins, so simultaneous wrong presses never raise miss.
  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_correct) begin
          w_hit_nxt   = 1'b1;
          w_state_nxt = LOCKED;
        end else begin
          w_miss_nxt  = w_any_press;
          w_state_nxt = w_mole_lit ? ARMED : IDLE;
        end
      end
      ARMED: begin
        if (w_correct) begin
          w_hit_nxt   = 1'b1;
          w_state_nxt = LOCKED;
        end else begin
          w_miss_nxt = w_any_press;
          if (w_mole_chg) begin
            w_state_nxt = w_mole_lit ? ARMED : IDLE;
          end
        end
      end
      LOCKED: begin
        if (w_mole_chg) begin
          if (w_correct) begin
            w_hit_nxt   = 1'b1;
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = w_mole_lit ? ARMED : IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign hit       = r_hit;
  assign miss      = r_miss;
  assign lockout   = r_lockout;
  assign btn_clean = w_clean;

endmodule

`default_nettype wire

// File: tb/tb_whack_hit_judge.sv
//------------------------------------------------------------------------------
// Module   : tb_whack_hit_judge
// Purpose  : Scoreboard bench for whack_hit_judge with a short debounce window.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_whack_hit_judge;

  localparam int N      = 4;
  localparam int D      = 4;
  localparam int K_NONE = 0;
  localparam int K_MISS = 1;
  localparam int K_HIT  = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] mole_sel = '0;
  logic         hit;
  logic         miss;
  logic [N-1:0] btn_clean;
  logic         lockout;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_q[$];
  int exp_count = 0;
  int obs_count = 0;
  bit mon_en    = 1'b0;

  whack_hit_judge #(
    .NUM_HOLES       (N),
    .DEBOUNCE_CYCLES (D),
    .DB_W            (3)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .mole_sel  (mole_sel),
    .hit       (hit),
    .miss      (miss),
    .btn_clean (btn_clean),
    .lockout   (lockout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Every observed pulse consumes one expected event; {hit,miss} encodes the kind.
  always @(negedge clock) begin
    if (mon_en && (hit || miss)) begin
      if (hit) obs_count++;
      if (exp_q.size() == 0) check("unexpected_pulse", {30'd0, hit, miss}, K_NONE);
      else                   check("pulse_kind", {30'd0, hit, miss}, exp_q.pop_front());
    end
  end

  task automatic press(input logic [N-1:0] mask, input int kind);
    int n;
    if (kind != K_NONE) exp_q.push_back(kind);
    if (kind == K_HIT) exp_count++;
    @(negedge clock);
    btn_raw = btn_raw | mask;
    n = 0;
    while (((btn_clean & mask) != mask) && (n < 20)) begin
      @(posedge clock); #1;
      n++;
    end
    check("clean_latency", n, D + 2);
    check("no_early_pulse", {30'd0, hit, miss}, K_NONE);
    @(posedge clock); #1;
    check("pulse_next_cycle", {30'd0, hit, miss}, kind);
    @(posedge clock); #1;
    check("pulse_width", {30'd0, hit, miss}, K_NONE);
  endtask

  task automatic release_all();
    @(negedge clock);
    btn_raw = '0;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic set_mole(input logic [N-1:0] v);
    @(negedge clock);
    mole_sel = v;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int flag;

    repeat (3) @(posedge clock);
    #1;
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_lockout", lockout, 0);
    check("rst_clean", btn_clean, 0);
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Clean press on the lit mole
    set_mole(4'b0100);
    press(4'b0100, K_HIT);
    check("t1_lockout", lockout, 1);
    check("t1_count", obs_count, 1);

    // Repeat press on a scored mole is ignored; a new mole re-arms
    release_all();
    press(4'b0100, K_NONE);
    check("t3_lockout_held", lockout, 1);
    release_all();
    set_mole(4'b0001);
    check("t3_lockout_clear", lockout, 0);
    press(4'b0001, K_HIT);
    check("t3_count", obs_count, 2);
    release_all();

    // Bouncing button never settles, then holds
    set_mole(4'b0000);
    set_mole(4'b0001);
    flag = 0;
    repeat (10) begin
      @(negedge clock);
      btn_raw[0] = ~btn_raw[0];
      repeat (2) begin
        @(posedge clock); #1;
        if (btn_clean[0]) flag = 1;
      end
    end
    check("t2_bounce_clean", flag, 0);
    press(4'b0001, K_HIT);
    check("t2_count", obs_count, 3);
    release_all();

    // Wrong hole then right hole
    set_mole(4'b0010);
    press(4'b1000, K_MISS);
    check("t4_lockout_armed", lockout, 0);
    press(4'b0010, K_HIT);
    check("t4_lockout", lockout, 1);
    release_all();

    // Correct and wrong on the same cycle, then press with no mole
    set_mole(4'b0001);
    set_mole(4'b0010);
    press(4'b1010, K_HIT);
    release_all();
    set_mole(4'b0000);
    check("t5_lockout_idle", lockout, 0);
    press(4'b0100, K_MISS);
    release_all();

    // Reset asserted mid-debounce while locked and a button is clean-high
    set_mole(4'b0001);
    press(4'b0001, K_HIT);
    check("t6_pre_lockout", lockout, 1);
    @(negedge clock);
    btn_raw[1] = 1'b1;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_async_clean", btn_clean, 0);
    check("t6_async_lockout", lockout, 0);
    check("t6_async_pulses", {30'd0, hit, miss}, K_NONE);
    btn_raw  = '0;
    mole_sel = '0;
    @(negedge clock);
    reset = 1'b0;
    flag  = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if ((btn_clean != '0) || hit || miss) flag++;
    end
    check("t6_quiet_after_reset", flag, 0);

    check("queue_drained", exp_q.size(), 0);
    check("final_count", obs_count, exp_count);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
